// File: rtl/dot_product_acc_pl.sv
// rtl/dot_product_acc_pl.sv - pipelined lane-wise multiply, adder-tree reduce, multi-line accumulate
module dot_product_acc_pl #(
    parameter int CACHE_WIDTH = 512,
    parameter int DATA_WIDTH  = 32,
    parameter int ACC_WIDTH   = 64,
    parameter int SIGNED      = 0,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   in_last,
    input  logic [CACHE_WIDTH-1:0] array1,
    input  logic [CACHE_WIDTH-1:0] array2,
    output logic [ACC_WIDTH-1:0]   res,
    output logic                   res_valid,
    output logic [CNT_WIDTH-1:0]   res_lines,
    output logic                   busy
);

    localparam int N = CACHE_WIDTH / DATA_WIDTH;
    localparam int L = $clog2(N);

    // One valid flag per pipeline stage: index 0 is the multiply stage, L the tree root.
    logic [L:0] pipe_v;

    genvar k, i;
    generate
        for (k = 0; k <= L; k++) begin : g_stage
            localparam int W = N >> k;
            logic [W*ACC_WIDTH-1:0] data_d;
            logic [W*ACC_WIDTH-1:0] data_q;
            logic                   v_q;
            logic                   l_q;

            if (k == 0) begin : g_mul
                for (i = 0; i < N; i++) begin : g_lane
                    logic [DATA_WIDTH-1:0] a;
                    logic [DATA_WIDTH-1:0] b;
                    logic [ACC_WIDTH-1:0]  a_ext;
                    logic [ACC_WIDTH-1:0]  b_ext;
                    assign a = array1[i*DATA_WIDTH +: DATA_WIDTH];
                    assign b = array2[i*DATA_WIDTH +: DATA_WIDTH];
                    if (SIGNED != 0) begin : g_sx
                        assign a_ext = {{(ACC_WIDTH-DATA_WIDTH){a[DATA_WIDTH-1]}}, a};
                        assign b_ext = {{(ACC_WIDTH-DATA_WIDTH){b[DATA_WIDTH-1]}}, b};
                    end else begin : g_zx
                        assign a_ext = {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, a};
                        assign b_ext = {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, b};
                    end
                    // Full-precision product, wrapped to the accumulator width.
                    assign data_d[i*ACC_WIDTH +: ACC_WIDTH] = a_ext * b_ext;
                end

                // Register lane products; only the valid flag needs reset, data in bubbles is don't-care.
                always_ff @(posedge clk) begin
                    data_q <= data_d;
                    l_q    <= in_valid & in_last;
                    if (rst) v_q <= 1'b0;
                    else     v_q <= in_valid;
                end
            end else begin : g_add
                for (i = 0; i < W; i++) begin : g_pair
                    assign data_d[i*ACC_WIDTH +: ACC_WIDTH] =
                        g_stage[k-1].data_q[(2*i)*ACC_WIDTH +: ACC_WIDTH] +
                        g_stage[k-1].data_q[(2*i+1)*ACC_WIDTH +: ACC_WIDTH];
                end

                // Register this tree level's pairwise sums and shift the beat flags along.
                always_ff @(posedge clk) begin
                    data_q <= data_d;
                    l_q    <= g_stage[k-1].l_q;
                    if (rst) v_q <= 1'b0;
                    else     v_q <= g_stage[k-1].v_q;
                end
            end

            assign pipe_v[k] = v_q;
        end
    endgenerate

    logic [ACC_WIDTH-1:0] tree_s;
    logic                 tree_v;
    logic                 tree_l;
    assign tree_s = g_stage[L].data_q[ACC_WIDTH-1:0];
    assign tree_v = g_stage[L].v_q;
    assign tree_l = g_stage[L].l_q;

    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;
    logic                 first_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic [ACC_WIDTH-1:0] res_q;
    logic                 res_valid_q;
    logic [CNT_WIDTH-1:0] res_lines_q;

    // Next accumulator value: a new vector starts from the tree sum, otherwise it adds on.
    always_comb begin
        acc_d   = first_q ? tree_s : acc_q + tree_s;
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    end

    // Accumulate valid tree outputs and publish the result on the vector's last line.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            first_q     <= 1'b1;
            cnt_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            res_lines_q <= '0;
        end else begin
            res_valid_q <= 1'b0;
            if (tree_v) begin
                acc_q <= acc_d;
                if (tree_l) begin
                    res_q       <= acc_d;
                    res_lines_q <= cnt_inc;
                    res_valid_q <= 1'b1;
                    first_q     <= 1'b1;
                    cnt_q       <= '0;
                end else begin
                    first_q <= 1'b0;
                    cnt_q   <= cnt_inc;
                end
            end
        end
    end

    assign res       = res_q;
    assign res_valid = res_valid_q;
    assign res_lines = res_lines_q;
    assign busy      = (|pipe_v) | ~first_q;

endmodule

// File: doc/dot_product_acc_pl.md
# dot_product_acc_pl

Pipelined, parametrised dot-product engine for the CCI-E datapath. Each beat multiplies two cache-line-wide vectors lane by lane and reduces the products through a log2(N)-deep registered adder tree. Unlike the single-line predecessor, it accumulates across a multi-line vector delimited by `in_last`, supports signed or unsigned lanes, and keeps full-precision products. It sits between the read-response path and the result write-back logic.

## Interface

- `CACHE_WIDTH`, 512: width of each input vector beat in bits.
- `DATA_WIDTH`, 32: lane width. `N = CACHE_WIDTH/DATA_WIDTH` must be a power of two, ≥ 2.
- `ACC_WIDTH`, 64: width of products, tree sums and the accumulator. Must satisfy ACC_WIDTH ≥ 2*DATA_WIDTH.
- `SIGNED`, 0: 0 treats lanes as unsigned; 1 treats lanes as two's-complement.
- `CNT_WIDTH`, 16: width of the line counter.

Ports (clock and reset first):

- `clk`, in, 1: the single clock. All state changes on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: `array1`/`array2` carry a valid beat this cycle.
- `in_last`, in, 1: the beat is the final line of the current vector. Qualified by `in_valid`.
- `array1`, in, CACHE_WIDTH: operand A. Lane i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `array2`, in, CACHE_WIDTH: operand B, same lane layout as `array1`.
- `res`, out, ACC_WIDTH: dot product of the most recently completed vector. Held until the next completion.
- `res_valid`, out, 1: one-cycle pulse when `res` updates.
- `res_lines`, out, CNT_WIDTH: number of lines in the completed vector. Saturates at all-ones. Updates with `res`.
- `busy`, out, 1: high while any beat is in the pipeline or a vector is partially accumulated.

## Operation

- There is no backpressure. A beat is accepted on every cycle with `in_valid=1`.
- Stage M (multiply):
  - Each lane is zero-extended (SIGNED=0) or sign-extended (SIGNED=1) to ACC_WIDTH.
  - Lanes are multiplied and the product is kept modulo 2^ACC_WIDTH.
  - `valid`/`last` are registered alongside the products.
- Stages T1..TL, with L = log2(N): stage Tk registers N/2^k pairwise sums of stage T(k-1).
  - The tree is built with a generate loop over k. It must not be hand-unrolled.
  - `valid`/`last` shift along with the data.
- Stage A (accumulate), on a valid tree output `s`:
  - If `first`: `acc_next = s`. Otherwise `acc_next = acc + s`, modulo 2^ACC_WIDTH.
  - `acc <= acc_next`, and the line counter is incremented (saturating).
  - If `last`: `res <= acc_next`, `res_lines <=` counter+1 (saturating), `res_valid <= 1`, `first <= 1`, counter cleared. Otherwise `first <= 0`.
- Invalid slots (bubbles) carry `valid=0` and leave `acc`, `first` and the counter unchanged. Data registers in bubble slots may hold anything and must not be observed.
- Back-to-back vectors:
  - A `last` beat may be followed immediately by the first beat of the next vector.
  - Vectors are kept independent by the `first` flag. No idle cycle is required between them.
- `busy = |pipeline valid flags | !first`.
- Reset, synchronous, any time (including mid-vector):
  - All pipeline valid flags are cleared. In-flight and partial data is discarded.
  - `acc=0`, `first=1`, counter=0.
  - `res=0`, `res_valid=0`, `res_lines=0`, `busy=0`.
  - A beat presented in the same cycle as `rst` is dropped.

## Timing

- Latency: L+2 cycles from the `in_valid & in_last` edge to the `res_valid` pulse.
  - For N=16, L=4: 6 cycles.
  - For CACHE_WIDTH=512, DATA_WIDTH=64, N=8: 5 cycles.
- Throughput: one line per cycle, sustained indefinitely.
- `res_valid` is high for exactly one cycle per completed vector.
- A one-line vector (`in_last` on its only beat) is legal and yields `res_lines=1`.
- Values after reset deassertion: `res` holds 0 until the first completion, and `res_valid` stays 0.

## Test plan

Defaults unless noted: CACHE_WIDTH=512, DATA_WIDTH=32, ACC_WIDTH=64, SIGNED=0.

1. One-line vector: lane i of `array1` = i+1, every lane of `array2` = 2, `in_last=1` at cycle T. Required: `res_valid` pulses at T+6 only, `res=272`, `res_lines=1`, `busy` low at T+7.
2. Three lines back-to-back, all lanes 1×1, `in_last` on the third. Required: one pulse, 6 cycles after the third beat, with `res=48` and `res_lines=3`. No pulse after lines 1 or 2.
3. Same three lines with 2 and 3 idle cycles inserted between beats. Required: `res=48`, `res_lines=3`, pulse 6 cycles after the final beat.
4. Sign handling: lane 0 = 0xFFFFFFFF × 5, other lanes 0, one line. Required:
   - SIGNED=1 instance gives `res=0xFFFFFFFFFFFFFFFB`.
   - SIGNED=0 instance gives `res=0x00000004FFFFFFFB`.
5. Consecutive vectors: vector X (1 line, all lanes 3×3, sum 144) at cycle T, then vector Y (1 line, all lanes 1×2, sum 32) at T+1. Required:
   - Pulses at T+6 (`res=144`) and T+7 (`res=32`).
   - `res_lines=1` on both pulses.
   - `res` stays 32 afterwards.
6. Reset mid-vector: issue 2 lines of a 3-line vector, assert `rst` for 1 cycle, then send a 1-line vector (all lanes 1×1). Required:
   - `busy=0` and `res=0` right after reset.
   - Exactly one pulse, with `res=16` and `res_lines=1`.
   - No contribution from the pre-reset lines.
